ntt_bf_sched: RTL
=================

# ntt_bf_sched

Issue scheduler for the radix-2 Cooley-Tukey NTT butterfly datapath.
- On `start`, it walks all LOGN stages and emits one butterfly descriptor per accepted handshake: operand addresses, twiddle index and stage number.
- It latches the modulus that drives the butterfly's modular add/sub units.
- It sits between the top-level NTT control and the coefficient-memory/butterfly pipeline, and signals `done` only after the last butterfly result has drained.

## Interface
- `LOGN`, default 10: log2 of transform length N; N/2 butterflies per stage.
- `BF_LAT`, default 4: butterfly pipeline latency in cycles, issue to write-back; must be ≥1.
- `QW`, default 28: modulus width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin transform; sampled only in IDLE.
- `q_in`  in  QW  modulus; latched when `start` is accepted.
- `q_out`  out  QW  latched modulus to the mod_add/mod_sub units.
- `issue_valid`  out  1  descriptor valid.
- `issue_ready`  in  1  datapath accepts descriptor.
- `addr_a`  out  LOGN  upper-leg coefficient address.
- `addr_b`  out  LOGN  lower-leg coefficient address.
- `tw_idx`  out  LOGN-1  twiddle ROM index.
- `stage`  out  $clog2(LOGN)  current stage s.
- `busy`  out  1  high in ISSUE or DRAIN.
- `done`  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE → ISSUE when `start`=1. Latch `q_in`; clear s and k.
  - ISSUE: `issue_valid`=1. Counter k advances only on `issue_valid & issue_ready`.
  - While valid and not ready, all descriptor outputs hold stable.
- Descriptor for stage s, butterfly k (0..N/2-1), with half=2^s:
  - j = k mod half
  - g = k >> s
  - `addr_a` = g·2·half + j
  - `addr_b` = `addr_a` + half
  - `tw_idx` = j << (LOGN-1-s)
- Handshake on k = N/2-1:
  - If s < LOGN-1: stage transition (see Configuration), then k ← 0, s ← s+1.
  - If s = LOGN-1: go to DRAIN.
- DRAIN counts BF_LAT cycles, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while not in IDLE is ignored. `q_out` is unchanged until the next accepted start.
- Reset asserted mid-transform: immediately IDLE; counters, `issue_valid`, `busy` and `done` go to 0. No `done` is produced for the aborted run.
- `issue_ready` is ignored outside ISSUE.
- Counters are unsigned. k wraps to 0 only at the stage boundary; the address arithmetic never exceeds N-1.

## Timing
- Reset values: all outputs 0, including `q_out`, addresses, `stage`, `busy`, `done` and `issue_valid`.
- `start` is sampled at cycle 0. The first descriptor is valid at cycle 1 (registered outputs, no combinational path from `start`).
- Throughput is 1 butterfly/cycle while `issue_ready`=1.
- `issue_valid` has no combinational dependence on `issue_ready`.
- Last accept at cycle t: DRAIN occupies t+1..t+BF_LAT, and `done` is high at t+BF_LAT+1.

## Configuration
- `NTT_STAGE_DRAIN_EN` defined:
  - After the last accept of each non-final stage, enter DRAIN for BF_LAT cycles, with `issue_valid`=0.
  - Then resume ISSUE with s+1. This avoids read-after-write hazards on a single-port coefficient RAM.
- Undefined:
  - Stages run back-to-back: the next descriptor (s+1, k=0) is valid the cycle after the last accept.
  - This is for ping-pong memories.
- The final drain before `done` is present in both builds.

## Test plan
- Reset, default parameters: all outputs 0, state IDLE. `start` with `q_in`=0x7FFE001 and `issue_ready`=1 → cycle 1: a=0, b=1, tw=0, s=0; cycle 2: a=2, b=3. `q_out`=0x7FFE001.
- Stage 1, k=1 → a=1, b=3, tw=256. Stage 9, k=1 → a=1, b=513, tw=1.
- Ready tied high, macro undefined → 5120 accepts on cycles 1..5120; `done` at cycle 5125 only.
  - Macro defined → `done` at cycle 5161, with `issue_valid` low for 4 cycles after each stage's 512th accept.
- `issue_ready` toggled 1,0,0,1 → outputs held stable while stalled. No butterfly skipped or duplicated; the full k sequence is checked per stage.
- `rst_n` pulsed low mid-stage 3 → outputs 0 asynchronously, no `done`. A new `start` restarts at s=0, k=0.
- `start` re-asserted while busy with a different `q_in` → ignored. `q_out` and the sequence are unchanged.

Source files
------------

// File: rtl/ntt_bf_sched.sv
// Issue scheduler for the radix-2 Cooley-Tukey NTT butterfly datapath.
// Define NTT_STAGE_DRAIN_EN to drain the butterfly pipeline between stages (single-port RAM).
module ntt_bf_sched #(
    parameter int  LOGN   = 10,
    parameter int  BF_LAT = 4,
    parameter int  QW     = 28,
    localparam int SW     = (LOGN > 1) ? $clog2(LOGN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [QW-1:0]   q_in,
    output logic [QW-1:0]   q_out,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-2:0] tw_idx,
    output logic [SW-1:0]   stage,
    output logic            busy,
    output logic            done,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam int KW = LOGN - 1;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   q_q, q_d;
    logic [LOGN-1:0] addr_a_q, addr_a_d;
    logic [LOGN-1:0] addr_b_q, addr_b_d;
    logic [KW-1:0]   tw_q, tw_d;

    logic            k_last;
    logic            s_last;
    logic            drain_end;

    logic [LOGN-1:0] k_ext;
    logic [LOGN-1:0] half;
    logic [LOGN-1:0] j;
    logic [LOGN-1:0] g;
    logic [LOGN-1:0] a_full;
    logic [LOGN-1:0] tw_full;
    logic [SW-1:0]   tw_sh;

    assign k_last    = (k_q == {KW{1'b1}});
    assign s_last    = (s_q == SW'(LOGN - 1));
    assign drain_end = (cnt_q == CW'(BF_LAT - 1));

    // Handshake: a descriptor is transferred on a rising edge where issue_valid
    // and issue_ready are both high; issue_valid depends only on registered state.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    q_d     = q_in;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    if (!k_last) begin
                        k_d = k_q + KW'(1);
                    end else if (s_last) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
`ifdef NTT_STAGE_DRAIN_EN
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
`else
                        s_d = s_q + SW'(1);
                        k_d = '0;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                // s is only advanced once the drain finishes, so s_last tells
                // the final drain apart from an inter-stage one.
                if (drain_end) begin
                    if (s_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Descriptor is registered from the next (s, k) so it is stable during stalls.
    always_comb begin
        k_ext   = {1'b0, k_d};
        half    = LOGN'(1) << s_d;
        j       = k_ext & (half - LOGN'(1));
        g       = k_ext >> s_d;
        a_full  = ((g << s_d) << 1) | j;
        tw_sh   = SW'(LOGN - 1) - s_d;
        tw_full = j << tw_sh;
        if (state_d == ST_ISSUE) begin
            addr_a_d = a_full;
            addr_b_d = a_full | half;
            tw_d     = tw_full[KW-1:0];
        end else begin
            addr_a_d = '0;
            addr_b_d = '0;
            tw_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    assign q_out       = q_q;
    assign issue_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign tw_idx      = tw_q;
    assign stage       = s_q;
    assign dbg_state   = state_q;

endmodule
